// File: rtl/output_layer_writer_pkg.sv
// Shared constants, state encoding and strobe helper for the output layer writer.
// Imported by the row buffer and the top-level writer.
package output_layer_writer_pkg;

    localparam int BURST_LEN   = 8;
    localparam int ROW_SHIFT   = 6;
    localparam int LAYER_SHIFT = 12;
    localparam int MAX_COLS    = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FILL = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_RESP = 3'd4;

    localparam logic [1:0] AW_BURST_INCR = 2'b01;
    localparam logic [2:0] AW_SIZE_8B    = 3'd3;
    localparam logic [3:0] AW_CACHE_BUF  = 4'b0011;

    // Lane j of beat k is live iff 8k+j < cols.
    function automatic logic [7:0] strb_for_beat(
        input logic [2:0] beat,
        input logic [6:0] cols
    );
        logic [7:0] s;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            s[j] = (7'({beat, 3'(j)}) < cols);
        end
        return s;
    endfunction

endpackage

// File: rtl/output_layer_writer_if.sv
// AXI4 write-address, write-data and write-response channels.
// master: drives AW/W and BREADY; slave: drives AWREADY/WREADY and B.
interface output_layer_writer_if #(
    parameter int ID_W   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/output_layer_writer_row.sv
// Single-row pixel buffer: 8 beats x 64 bits, byte write per pixel, beat read-out.
// Ports: clk, reset_n, clear, wr_en/wr_col/wr_data, rd_beat, cols -> rd_data, rd_strb.
module output_row_buffer
    import output_layer_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [5:0]  wr_col,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  rd_beat,
    input  logic [6:0]  cols,
    output logic [63:0] rd_data,
    output logic [7:0]  rd_strb
);

    logic [63:0] mem [BURST_LEN];

    // Lanes past cols are never written within a run, so clearing on
    // each accepted start keeps them at zero for every row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BURST_LEN; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < BURST_LEN; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_col[5:3]][{wr_col[2:0], 3'b000} +: 8] <= wr_data;
        end
    end

    assign rd_data = mem[rd_beat];
    assign rd_strb = strb_for_beat(rd_beat, cols);

endmodule

// File: rtl/output_layer_writer.sv
// Streams output pixels (row, layer, col order) into one 8-beat AXI4 burst per row.
// Ports: clk, reset_n, config + start, busy/done/bresp_error, pixel stream, m_axi master.
module output_layer_writer
    import output_layer_writer_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_BURST_LEN  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_address,
    input  logic [9:0]                    no_of_output_layers,
    input  logic [9:0]                    output_layer_row_size,
    input  logic [9:0]                    output_layer_col_size,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          bresp_error,
    input  logic [7:0]                    output_layer_1_data,
    input  logic                          output_layer_1_valid,
    output logic                          output_layer_1_rdy,
    output_layer_writer_if.master         m_axi
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    state_t        state;
    logic [AW-1:0] cfg_base;
    logic [9:0]    cfg_layers;
    logic [6:0]    cfg_rows;
    logic [6:0]    cfg_cols;
    logic [5:0]    col;
    logic [9:0]    layer;
    logic [5:0]    row;
    logic [2:0]    beat;

    logic cfg_ok, accept, px_fire, last_col, last_beat, last_seg;
    logic [63:0] buf_data;
    logic [7:0]  buf_strb;
    logic        unused_ok;

    assign cfg_ok = (no_of_output_layers != '0)
                 && (output_layer_row_size != '0)
                 && (output_layer_col_size != '0)
                 && (output_layer_row_size <= 10'(MAX_COLS))
                 && (output_layer_col_size <= 10'(MAX_COLS));

    assign accept    = (state == ST_IDLE) && start && cfg_ok;
    assign px_fire   = (state == ST_FILL) && output_layer_1_valid;
    assign last_col  = (col == 6'(cfg_cols - 7'd1));
    assign last_beat = (beat == 3'(BURST_LEN - 1));
    assign last_seg  = (layer == cfg_layers - 10'd1)
                    && (row == 6'(cfg_rows - 7'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cfg_base    <= '0;
            cfg_layers  <= '0;
            cfg_rows    <= '0;
            cfg_cols    <= '0;
            col         <= '0;
            layer       <= '0;
            row         <= '0;
            beat        <= '0;
            done        <= 1'b0;
            bresp_error <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cfg_base    <= axi_address;
                        cfg_layers  <= no_of_output_layers;
                        cfg_rows    <= output_layer_row_size[6:0];
                        cfg_cols    <= output_layer_col_size[6:0];
                        col         <= '0;
                        layer       <= '0;
                        row         <= '0;
                        beat        <= '0;
                        bresp_error <= 1'b0;
                        state       <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (px_fire) begin
                        if (last_col) begin
                            col   <= '0;
                            state <= ST_ADDR;
                        end else begin
                            col <= col + 6'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi.awready) begin
                        beat  <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi.wready) begin
                        beat <= beat + 3'd1;
                        if (last_beat) state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != 2'b00) bresp_error <= 1'b1;
                        if (last_seg) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            // Layer is the fast index; row advances on wrap.
                            if (layer == cfg_layers - 10'd1) begin
                                layer <= '0;
                                row   <= row + 6'd1;
                            end else begin
                                layer <= layer + 10'd1;
                            end
                            state <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    output_row_buffer u_row (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .wr_en   (px_fire),
        .wr_col  (col),
        .wr_data (output_layer_1_data),
        .rd_beat (beat),
        .cols    (cfg_cols),
        .rd_data (buf_data),
        .rd_strb (buf_strb)
    );

    assign busy               = (state != ST_IDLE);
    assign output_layer_1_rdy = (state == ST_FILL);

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = cfg_base
                         + (AW'(layer) << LAYER_SHIFT)
                         + (AW'(row) << ROW_SHIFT);
    assign m_axi.awlen   = 8'(C_S_AXI_BURST_LEN - 1);
    assign m_axi.awsize  = AW_SIZE_8B;
    assign m_axi.awburst = AW_BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AW_CACHE_BUF;
    assign m_axi.awprot  = 3'd0;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.awvalid = (state == ST_ADDR);

    assign m_axi.wdata  = buf_data;
    assign m_axi.wstrb  = SW'(buf_strb);
    assign m_axi.wlast  = (state == ST_DATA) && last_beat;
    assign m_axi.wvalid = (state == ST_DATA);
    assign m_axi.bready = (state == ST_RESP);

    assign unused_ok = ^{1'b0, m_axi.bid};

endmodule
